// File: rtl/mac_pkg.sv
// Shared constants and read-side state type for the three-FIFO multiply-add controller.
package mac_pkg;

    localparam int DATA_WIDTH = 32;
    localparam int DEPTH      = 16;
    localparam int OCC_W      = 5;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        WAIT = 2'd1,
        HOLD = 2'd2
    } state_t;

endpackage

// File: rtl/mac_fifo_ctrl.sv
// Controller for the three-FIFO multiply-add datapath (result = a*b + c).
// Pushes operand triples into FIFO1..3 in lockstep, pops all three together,
// captures the datapath result and holds it on a valid/ready output.
// Optional feature macro: MAC_FIFO_CTRL_STATS_EN adds the res_count output.
module mac_fifo_ctrl
    import mac_pkg::*;
(
    input  logic                    clk,
    input  logic                    rst,
    input  logic                    in_valid,
    output logic                    in_ready,
    input  logic [DATA_WIDTH-1:0]   in_a,
    input  logic [DATA_WIDTH-1:0]   in_b,
    input  logic [DATA_WIDTH-1:0]   in_c,
    output logic                    fifo_wr,
    output logic [3*DATA_WIDTH-1:0] fifo_wdata,
    output logic                    fifo_rd,
    input  logic [2:0]              fifo_empty,
    input  logic [2:0]              fifo_full,
    input  logic [DATA_WIDTH-1:0]   mac_result,
    output logic                    res_valid,
    input  logic                    res_ready,
    output logic [DATA_WIDTH-1:0]   res_data,
    output logic                    err
`ifdef MAC_FIFO_CTRL_STATS_EN
    ,
    output logic [15:0]             res_count
`endif
);

    state_t           state;
    logic [OCC_W-1:0] occ;
    logic             active;
    logic             occ_zero;
    logic             occ_full;
    logic             err_now;

    // Held low during reset and released on the first clock after it, so
    // in_ready (and everything derived from it) is 0 while rst is asserted.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) active <= 1'b0;
        else      active <= 1'b1;
    end

    // Write-side handshake, pop request and lockstep consistency checks.
    always_comb begin
        occ_zero   = (occ == '0);
        occ_full   = (occ == OCC_W'(DEPTH));
        in_ready   = active & ~occ_full & ~|fifo_full;
        fifo_wr    = in_valid & in_ready;
        fifo_wdata = {in_c, in_b, in_a} & {3*DATA_WIDTH{active}};
        // Pop only from IDLE with data present in all three FIFOs and no
        // result still waiting downstream; this is a one-cycle pulse because
        // the FSM leaves IDLE on the same edge.
        fifo_rd    = active & (state == IDLE) & ~occ_zero & ~|fifo_empty & ~res_valid;
        err_now    = ((fifo_empty != 3'b000) & (fifo_empty != 3'b111))
                   | ((fifo_full  != 3'b000) & (fifo_full  != 3'b111))
                   | (occ_zero & ~&fifo_empty)
                   | (occ_full & ~&fifo_full);
    end

    // Occupancy tracks writes minus pops; both are already blocked at the
    // limits, so a simultaneous write and pop simply leaves it unchanged.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            occ <= '0;
        end else if (fifo_wr && !fifo_rd) begin
            occ <= occ + 1'b1;
        end else if (fifo_rd && !fifo_wr) begin
            occ <= occ - 1'b1;
        end
    end

    // Read-side FSM: pop, wait one cycle for FIFO data_out, then hold the
    // captured result until the downstream handshake.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state     <= IDLE;
            res_valid <= 1'b0;
            res_data  <= '0;
        end else begin
            case (state)
                IDLE: begin
                    if (fifo_rd) state <= WAIT;
                end
                WAIT: begin
                    res_data  <= mac_result;
                    res_valid <= 1'b1;
                    state     <= HOLD;
                end
                HOLD: begin
                    if (res_ready) begin
                        res_valid <= 1'b0;
                        state     <= IDLE;
                    end
                end
                default: begin
                    res_valid <= 1'b0;
                    state     <= IDLE;
                end
            endcase
        end
    end

    // Sticky error: once the flags disagree with each other or with occ,
    // it stays set until reset.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst)         err <= 1'b0;
        else if (err_now) err <= 1'b1;
    end

`ifdef MAC_FIFO_CTRL_STATS_EN
    // Count result handshakes; wraps from 0xFFFF to 0.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst)                       res_count <= '0;
        else if (res_valid & res_ready) res_count <= res_count + 16'd1;
    end
`endif

endmodule

// File: tb/tb_mac_fifo_ctrl.sv
// Testbench for mac_fifo_ctrl: behavioural three-FIFO datapath plus a queue of
// expected a*b+c results derived from the operands the bench pushes.
module tb_mac_fifo_ctrl;
    import mac_pkg::*;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        in_valid = 1'b0;
    logic        in_ready;
    logic [31:0] in_a = '0;
    logic [31:0] in_b = '0;
    logic [31:0] in_c = '0;
    logic        fifo_wr;
    logic [95:0] fifo_wdata;
    logic        fifo_rd;
    logic [2:0]  fifo_empty;
    logic [2:0]  fifo_full;
    logic [31:0] mac_result;
    logic        res_valid;
    logic        res_ready = 1'b0;
    logic [31:0] res_data;
    logic        err;
`ifdef MAC_FIFO_CTRL_STATS_EN
    logic [15:0] res_count;
`endif

    int checks = 0;
    int errors = 0;

    // Datapath model: three FIFOs of depth 16 with registered data_out.
    logic [31:0] qa[$];
    logic [31:0] qb[$];
    logic [31:0] qc[$];
    int          cnt;
    logic [31:0] da, db, dc;
    logic        force_en = 1'b0;
    logic [2:0]  force_empty = 3'b111;

    // Expected results in push order.
    logic [31:0] exp_q[$];

    always #5 clk = ~clk;

    mac_fifo_ctrl dut (
        .clk        (clk),
        .rst        (rst),
        .in_valid   (in_valid),
        .in_ready   (in_ready),
        .in_a       (in_a),
        .in_b       (in_b),
        .in_c       (in_c),
        .fifo_wr    (fifo_wr),
        .fifo_wdata (fifo_wdata),
        .fifo_rd    (fifo_rd),
        .fifo_empty (fifo_empty),
        .fifo_full  (fifo_full),
        .mac_result (mac_result),
        .res_valid  (res_valid),
        .res_ready  (res_ready),
        .res_data   (res_data),
        .err        (err)
`ifdef MAC_FIFO_CTRL_STATS_EN
        ,
        .res_count  (res_count)
`endif
    );

    always @(posedge clk or negedge rst) begin
        if (!rst) begin
            qa.delete();
            qb.delete();
            qc.delete();
            cnt <= 0;
            da  <= '0;
            db  <= '0;
            dc  <= '0;
        end else begin
            if (fifo_rd && qa.size() != 0) begin
                da <= qa.pop_front();
                db <= qb.pop_front();
                dc <= qc.pop_front();
            end
            if (fifo_wr) begin
                qa.push_back(fifo_wdata[31:0]);
                qb.push_back(fifo_wdata[63:32]);
                qc.push_back(fifo_wdata[95:64]);
            end
            cnt <= cnt + (fifo_wr ? 1 : 0) - ((fifo_rd && cnt != 0) ? 1 : 0);
        end
    end

    assign fifo_empty = force_en ? force_empty : {3{cnt == 0}};
    assign fifo_full  = {3{cnt >= 16}};
    assign mac_result = da * db + dc;

    function automatic logic [31:0] rand_op();
        case ($urandom_range(0, 7))
            0:       return 32'h0000_0000;
            1:       return 32'hFFFF_FFFF;
            default: return $urandom;
        endcase
    endfunction

    task automatic test_reset();
        #2 rst = 1'b0;
        repeat (2) @(negedge clk);
        checks++;
        if ({in_ready, fifo_wr, fifo_rd, res_valid, err, res_data, fifo_wdata} !== '0) begin
            errors++;
            $display("FAIL reset_outputs got rdy=%0b wr=%0b rd=%0b vld=%0b err=%0b data=%h expected all 0",
                     in_ready, fifo_wr, fifo_rd, res_valid, err, res_data);
        end
        rst = 1'b1;
        @(negedge clk);
        checks++;
        if (in_ready !== 1'b1) begin
            errors++;
            $display("FAIL reset_release_ready got %0b expected 1", in_ready);
        end
    endtask

    task automatic test_single_op();
        @(negedge clk);
        res_ready = 1'b0;
        in_valid = 1'b1; in_a = 32'd3; in_b = 32'd5; in_c = 32'd7;
        #1;
        checks++;
        if (fifo_wr !== 1'b1 || fifo_wdata !== {32'd7, 32'd5, 32'd3}) begin
            errors++;
            $display("FAIL single_write got wr=%0b wdata=%h expected wr=1 wdata=%h",
                     fifo_wr, fifo_wdata, {32'd7, 32'd5, 32'd3});
        end
        @(negedge clk);
        in_valid = 1'b0;
        #1;
        checks++;
        if (fifo_wr !== 1'b0 || fifo_rd !== 1'b1) begin
            errors++;
            $display("FAIL single_pop got wr=%0b rd=%0b expected wr=0 rd=1", fifo_wr, fifo_rd);
        end
        @(negedge clk);
        checks++;
        if (fifo_rd !== 1'b0 || res_valid !== 1'b0) begin
            errors++;
            $display("FAIL single_wait got rd=%0b vld=%0b expected rd=0 vld=0", fifo_rd, res_valid);
        end
        @(negedge clk);
        checks++;
        if (res_valid !== 1'b1 || res_data !== 32'd22) begin
            errors++;
            $display("FAIL single_result got vld=%0b data=%0d expected vld=1 data=22", res_valid, res_data);
        end
        res_ready = 1'b1;
        @(negedge clk);
        res_ready = 1'b0;
        #1;
        checks++;
        if (res_valid !== 1'b0 || fifo_rd !== 1'b0) begin
            errors++;
            $display("FAIL single_done got vld=%0b rd=%0b expected 0 0", res_valid, fifo_rd);
        end
    endtask

    task automatic test_backpressure();
        logic [31:0] e0, e1;
        int n;
        res_ready = 1'b0;
        @(negedge clk);
        in_valid = 1'b1; in_a = rand_op(); in_b = rand_op(); in_c = rand_op();
        e0 = in_a * in_b + in_c;
        @(negedge clk);
        in_a = rand_op(); in_b = rand_op(); in_c = rand_op();
        e1 = in_a * in_b + in_c;
        @(negedge clk);
        in_valid = 1'b0;
        n = 0;
        while (res_valid !== 1'b1 && n < 10) begin
            @(negedge clk);
            n++;
        end
        checks++;
        if (res_valid !== 1'b1 || res_data !== e0) begin
            errors++;
            $display("FAIL bp_first got vld=%0b data=%h expected vld=1 data=%h", res_valid, res_data, e0);
        end
        for (int i = 0; i < 10; i++) begin
            @(negedge clk);
            checks++;
            if (res_valid !== 1'b1 || res_data !== e0 || fifo_rd !== 1'b0) begin
                errors++;
                $display("FAIL bp_hold cycle %0d got vld=%0b data=%h rd=%0b expected vld=1 data=%h rd=0",
                         i, res_valid, res_data, fifo_rd, e0);
            end
        end
        res_ready = 1'b1;
        @(negedge clk);
        res_ready = 1'b0;
        #1;
        checks++;
        if (fifo_rd !== 1'b1 || res_valid !== 1'b0) begin
            errors++;
            $display("FAIL bp_release got rd=%0b vld=%0b expected rd=1 vld=0", fifo_rd, res_valid);
        end
        n = 0;
        while (res_valid !== 1'b1 && n < 10) begin
            @(negedge clk);
            n++;
        end
        checks++;
        if (res_valid !== 1'b1 || res_data !== e1) begin
            errors++;
            $display("FAIL bp_second got vld=%0b data=%h expected vld=1 data=%h", res_valid, res_data, e1);
        end
        res_ready = 1'b1;
        @(negedge clk);
        res_ready = 1'b0;
    endtask

    task automatic test_fill();
        res_ready = 1'b0;
        @(negedge clk);
        in_valid = 1'b1; in_a = rand_op(); in_b = rand_op(); in_c = rand_op();
        exp_q.push_back(in_a * in_b + in_c);
        @(negedge clk);
        in_valid = 1'b0;
        repeat (2) @(negedge clk);
        checks++;
        if (res_valid !== 1'b1) begin
            errors++;
            $display("FAIL fill_hold got vld=%0b expected 1", res_valid);
        end
        for (int i = 0; i < 16; i++) begin
            @(negedge clk);
            in_valid = 1'b1; in_a = rand_op(); in_b = rand_op(); in_c = rand_op();
            #1;
            checks++;
            if (in_ready !== 1'b1 || fifo_wr !== 1'b1) begin
                errors++;
                $display("FAIL fill_push %0d got rdy=%0b wr=%0b expected 1 1", i, in_ready, fifo_wr);
            end
            exp_q.push_back(in_a * in_b + in_c);
        end
        @(negedge clk);
        in_a = rand_op(); in_b = rand_op(); in_c = rand_op();
        #1;
        checks++;
        if (in_ready !== 1'b0 || fifo_wr !== 1'b0 || dut.occ !== 5'd16) begin
            errors++;
            $display("FAIL fill_full got rdy=%0b wr=%0b occ=%0d expected rdy=0 wr=0 occ=16",
                     in_ready, fifo_wr, dut.occ);
        end
        @(negedge clk);
        in_valid = 1'b0;
    endtask

    task automatic test_random_stream();
        int          pushed = 0;
        logic        prev_hold = 1'b0;
        logic [31:0] prev_data = '0;
        for (int cyc = 0; cyc < 3000 && !(pushed == 40 && exp_q.size() == 0); cyc++) begin
            @(negedge clk);
            if (prev_hold) begin
                checks++;
                if (res_valid !== 1'b1 || res_data !== prev_data) begin
                    errors++;
                    $display("FAIL rnd_stable got vld=%0b data=%h expected vld=1 data=%h",
                             res_valid, res_data, prev_data);
                end
            end
            in_valid  = (pushed < 40) ? 1'($urandom_range(0, 1)) : 1'b0;
            in_a      = rand_op(); in_b = rand_op(); in_c = rand_op();
            res_ready = ($urandom_range(0, 3) != 0);
            #1;
            checks++;
            if (in_ready !== (cnt < 16)) begin
                errors++;
                $display("FAIL rnd_ready got %0b expected %0b (fifo count %0d)", in_ready, (cnt < 16), cnt);
            end
            if (in_valid && in_ready) begin
                exp_q.push_back(in_a * in_b + in_c);
                pushed++;
            end
            if (res_valid && res_ready) begin
                checks++;
                if (exp_q.size() == 0 || res_data !== exp_q[0]) begin
                    errors++;
                    $display("FAIL rnd_result got %h expected %h (queued %0d)",
                             res_data, (exp_q.size() != 0) ? exp_q[0] : 32'h0, exp_q.size());
                end
                if (exp_q.size() != 0) void'(exp_q.pop_front());
            end
            prev_hold = res_valid && !res_ready;
            prev_data = res_data;
        end
        @(negedge clk);
        in_valid  = 1'b0;
        res_ready = 1'b0;
        checks++;
        if (exp_q.size() != 0 || pushed != 40 || err !== 1'b0) begin
            errors++;
            $display("FAIL rnd_drain got pending=%0d pushed=%0d err=%0b expected 0 40 0",
                     exp_q.size(), pushed, err);
        end
    endtask

    task automatic test_simul_push_pop();
        res_ready = 1'b0;
        @(negedge clk);
        in_valid = 1'b1; in_a = 32'hFFFF_FFFF; in_b = 32'd2; in_c = 32'd1;
        exp_q.push_back(32'hFFFF_FFFF);
        @(negedge clk);
        in_valid = 1'b0;
        repeat (2) @(negedge clk);
        checks++;
        if (res_valid !== 1'b1 || res_data !== 32'hFFFF_FFFF) begin
            errors++;
            $display("FAIL simul_wrap got vld=%0b data=%h expected vld=1 data=ffffffff", res_valid, res_data);
        end
        for (int i = 0; i < 8; i++) begin
            @(negedge clk);
            in_valid = 1'b1; in_a = rand_op(); in_b = rand_op(); in_c = rand_op();
            exp_q.push_back(in_a * in_b + in_c);
        end
        @(negedge clk);
        in_valid  = 1'b0;
        res_ready = 1'b1;
        #1;
        checks++;
        if (dut.occ !== 5'd8) begin
            errors++;
            $display("FAIL simul_occ_before got %0d expected 8", dut.occ);
        end
        void'(exp_q.pop_front());
        @(negedge clk);
        res_ready = 1'b0;
        in_valid = 1'b1; in_a = rand_op(); in_b = rand_op(); in_c = rand_op();
        exp_q.push_back(in_a * in_b + in_c);
        #1;
        checks++;
        if (fifo_rd !== 1'b1 || fifo_wr !== 1'b1) begin
            errors++;
            $display("FAIL simul_both got rd=%0b wr=%0b expected 1 1", fifo_rd, fifo_wr);
        end
        @(negedge clk);
        in_valid = 1'b0;
        #1;
        checks++;
        if (dut.occ !== 5'd8) begin
            errors++;
            $display("FAIL simul_occ_after got %0d expected 8", dut.occ);
        end
    endtask

    task automatic test_back_to_back();
        int rds = 0;
        res_ready = 1'b1;
        for (int cyc = 0; cyc < 200 && exp_q.size() != 0; cyc++) begin
            @(negedge clk);
            if (cyc < 9 && fifo_rd === 1'b1) rds++;
            if (res_valid === 1'b1) begin
                checks++;
                if (res_data !== exp_q[0]) begin
                    errors++;
                    $display("FAIL b2b_result got %h expected %h", res_data, exp_q[0]);
                end
                void'(exp_q.pop_front());
            end
        end
        @(negedge clk);
        res_ready = 1'b0;
        checks++;
        if (rds != 3 || exp_q.size() != 0) begin
            errors++;
            $display("FAIL b2b_throughput got %0d pops in 9 cycles, pending=%0d expected 3 and 0",
                     rds, exp_q.size());
        end
    endtask

    task automatic test_reset_mid_hold();
        res_ready = 1'b0;
        @(negedge clk);
        in_valid = 1'b1; in_a = rand_op(); in_b = rand_op(); in_c = rand_op();
        @(negedge clk);
        in_valid = 1'b0;
        repeat (2) @(negedge clk);
        in_valid = 1'b1; in_a = rand_op(); in_b = rand_op(); in_c = rand_op();
        @(negedge clk);
        in_valid = 1'b0;
        checks++;
        if (res_valid !== 1'b1) begin
            errors++;
            $display("FAIL midrst_pre got vld=%0b expected 1", res_valid);
        end
        rst = 1'b0;
        #1;
        checks++;
        if ({in_ready, fifo_wr, fifo_rd, res_valid, err, res_data} !== '0 || dut.occ !== 5'd0) begin
            errors++;
            $display("FAIL midrst_outputs got rdy=%0b wr=%0b rd=%0b vld=%0b err=%0b data=%h occ=%0d expected all 0",
                     in_ready, fifo_wr, fifo_rd, res_valid, err, res_data, dut.occ);
        end
        @(negedge clk);
        rst = 1'b1;
        exp_q.delete();
        @(negedge clk);
        checks++;
        if (in_ready !== 1'b1 || res_valid !== 1'b0 || fifo_rd !== 1'b0) begin
            errors++;
            $display("FAIL midrst_release got rdy=%0b vld=%0b rd=%0b expected 1 0 0", in_ready, res_valid, fifo_rd);
        end
    endtask

    task automatic test_lockstep();
        checks++;
        if (err !== 1'b0) begin
            errors++;
            $display("FAIL lock_pre got err=%0b expected 0", err);
        end
        force_empty = 3'b110;
        force_en    = 1'b1;
        @(negedge clk);
        checks++;
        if (err !== 1'b1) begin
            errors++;
            $display("FAIL lock_set got err=%0b expected 1", err);
        end
        force_en = 1'b0;
        repeat (4) @(negedge clk);
        checks++;
        if (err !== 1'b1) begin
            errors++;
            $display("FAIL lock_sticky got err=%0b expected 1", err);
        end
        rst = 1'b0;
        #1;
        checks++;
        if (err !== 1'b0) begin
            errors++;
            $display("FAIL lock_clear got err=%0b expected 0", err);
        end
        @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
    endtask

`ifdef MAC_FIFO_CTRL_STATS_EN
    task automatic test_stats();
        res_ready = 1'b1;
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            in_valid = 1'b1; in_a = rand_op(); in_b = rand_op(); in_c = rand_op();
        end
        @(negedge clk);
        in_valid = 1'b0;
        repeat (12) @(negedge clk);
        res_ready = 1'b0;
        checks++;
        if (res_count !== 16'd3) begin
            errors++;
            $display("FAIL stats_count got %0d expected 3", res_count);
        end
    endtask
`endif

    initial begin
        #1000000;
        $display("FAIL watchdog simulation did not finish in time");
        $fatal(1, "watchdog");
    end

    initial begin
        test_reset();
        test_single_op();
        test_backpressure();
        test_fill();
        test_random_stream();
        test_simul_push_pop();
        test_back_to_back();
        test_reset_mid_hold();
        test_lockstep();
`ifdef MAC_FIFO_CTRL_STATS_EN
        test_stats();
`endif
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
